// File: rtl/io_seq_pkg.sv
// io_seq_pkg: shared state encoding and default sizes for the IO load sequencer.
package io_seq_pkg;
   localparam int ADDR_W_DEF  = 16;
   localparam int CNT_W_DEF   = 16;
   localparam int TIMEOUT_DEF = 1024;
   typedef enum logic [1:0] {IDLE, DECOMP, DMA, FINISH} state_t;
endpackage

// File: rtl/io_seq_watchdog.sv
// io_seq_watchdog: counts waiting cycles and flags expiry on the LIMIT-th one.
module io_seq_watchdog #(
   parameter int LIMIT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic expired
);
   localparam int W = $clog2(LIMIT + 1);
   logic [W-1:0] cnt;
   assign expired = ~clr & (cnt == W'(LIMIT - 1));
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else     cnt <= clr ? '0 : cnt + 1'b1;
endmodule

// File: rtl/io_load_sequencer.sv
// io_load_sequencer: single-clock FSM driving decompressor/DMA per word for IO loads.
// Define IO_SEQ_TIMEOUT_EN to abort stalled waits after TIMEOUT cycles.
module io_load_sequencer
   import io_seq_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              interrupt,
   input  logic              load,
   input  logic              cnn_img,
   input  logic [CNT_W-1:0]  len,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              decomp_en,
   input  logic              decomp_done,
   output logic              dma_en,
   output logic [ADDR_W-1:0] dma_addr,
   input  logic              dma_done,
   output logic              io_if_en,
   output logic              busy,
   output logic              done,
   output logic              error
);
   state_t            state;
   logic              prev_int, img_q, expired;
   logic [CNT_W-1:0]  len_q, count, cnt_nx;
   logic [ADDR_W-1:0] base_q;
   wire int_edge = interrupt & ~prev_int;
   wire waiting  = (state == DECOMP) | (state == DMA);
   wire accepted = (state == DECOMP & decomp_done) | (state == DMA & dma_done);
   assign cnt_nx = count + 1'b1;
`ifdef IO_SEQ_TIMEOUT_EN
   io_seq_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clr     (~waiting | accepted),
      .expired (expired)
   );
`else
   // Never true; keeps TIMEOUT referenced when the watchdog is absent.
   assign expired = TIMEOUT < 0;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= IDLE;
         prev_int  <= 1'b0;
         img_q     <= 1'b0;
         len_q     <= '0;
         base_q    <= '0;
         count     <= '0;
         dma_addr  <= '0;
         decomp_en <= 1'b0;
         dma_en    <= 1'b0;
         io_if_en  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         prev_int <= interrupt;
         io_if_en <= (state == IDLE) & interrupt & ~load;
         done     <= 1'b0;
         error    <= 1'b0;
         case (state)
            IDLE: begin
               busy <= 1'b0;
               if (int_edge & load) begin
                  img_q  <= cnn_img;
                  len_q  <= len;
                  base_q <= base_addr;
                  count  <= '0;
                  busy   <= 1'b1;
                  if (len == '0) state <= FINISH;
                  else if (cnn_img) begin
                     state     <= DECOMP;
                     decomp_en <= 1'b1;
                  end else begin
                     state    <= DMA;
                     dma_en   <= 1'b1;
                     dma_addr <= base_addr;
                  end
               end
            end
            DECOMP:
               if (decomp_done) begin
                  state     <= DMA;
                  decomp_en <= 1'b0;
                  dma_en    <= 1'b1;
                  dma_addr  <= base_q + ADDR_W'(count);
               end else if (expired) begin
                  state     <= IDLE;
                  decomp_en <= 1'b0;
                  error     <= 1'b1;
               end
            DMA:
               if (dma_done) begin
                  count <= cnt_nx;
                  if (cnt_nx == len_q) begin
                     state  <= FINISH;
                     dma_en <= 1'b0;
                  end else if (img_q) begin
                     state     <= DECOMP;
                     dma_en    <= 1'b0;
                     decomp_en <= 1'b1;
                  end else dma_addr <= base_q + ADDR_W'(cnt_nx);
               end else if (expired) begin
                  state  <= IDLE;
                  dma_en <= 1'b0;
                  error  <= 1'b1;
               end
            FINISH: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_io_load_sequencer.sv
// tb_io_load_sequencer: scoreboard bench; expected requests queued at stimulus, checked as each is acknowledged.
module tb_io_load_sequencer;
   logic clk = 0, rst = 1, interrupt = 0, load = 0, cnn_img = 0, decomp_done = 0, dma_done = 0;
   logic [15:0] len = 0, base_addr = 0, dma_addr;
   logic decomp_en, dma_en, io_if_en, busy, done, error;
   int checks = 0, errors = 0, done_cnt = 0, err_cnt = 0, dec_cyc = 0, dma_cyc = 0, dly = 0, wcnt = 0;
   int d0, e0, c0, m0;
   bit rsp_on = 0, man_dec = 0, man_dma = 0, got;
   logic [16:0] exp_q[$];

   io_load_sequencer #(.ADDR_W(16), .CNT_W(16), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .interrupt(interrupt), .load(load), .cnn_img(cnn_img),
      .len(len), .base_addr(base_addr), .decomp_en(decomp_en), .decomp_done(decomp_done),
      .dma_en(dma_en), .dma_addr(dma_addr), .dma_done(dma_done), .io_if_en(io_if_en),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      checks++;
      if (got_v !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
      end
   endtask

   task automatic sb(input logic [16:0] req);
      if (exp_q.size() == 0) check("sb_unexpected_req", 32'(req), 32'h1ffff);
      else check("sb_req", 32'(req), 32'(exp_q.pop_front()));
   endtask

   // Responder: acknowledges the active request dly cycles after it appears.
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (error) err_cnt++;
      if (decomp_en) dec_cyc++;
      if (dma_en) dma_cyc++;
      decomp_done = man_dec;
      dma_done = man_dma;
      if (rsp_on && (decomp_en || dma_en)) begin
         if (wcnt >= dly) begin
            wcnt = 0;
            if (decomp_en) begin decomp_done = 1; sb({1'b0, 16'h0}); end
            else begin dma_done = 1; sb({1'b1, dma_addr}); end
         end else wcnt++;
      end else wcnt = 0;
   end

   task automatic start(input logic ld, input logic img, input logic [15:0] n, input logic [15:0] b);
      @(posedge clk); #1;
      load = ld; cnn_img = img; len = n; base_addr = b; interrupt = 1;
      @(posedge clk); #1;
      interrupt = 0;
   endtask

   task automatic wait_done(input string tag);
      bit seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin @(negedge clk); seen = done; end
      check(tag, 32'(seen), 1);
      if (seen) begin
         check({tag, "_busy_hi"}, 32'(busy), 1);
         @(negedge clk);
         check({tag, "_busy_lo"}, 32'(busy), 0);
      end
   endtask

   task automatic wait_for(input string tag, input bit on_dma);
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = on_dma ? dma_en : decomp_en; end
      check(tag, 32'(seen), 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_outs", {26'd0, decomp_en, dma_en, io_if_en, busy, done, error}, 0);
      check("rst_addr", 32'(dma_addr), 0);
      @(posedge clk); #1 rst = 0;

      // Image load, acks two cycles after each request
      d0 = done_cnt; dly = 2; rsp_on = 1;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back({1'b0, 16'h0});
         exp_q.push_back({1'b1, 16'h0100 + 16'(i)});
      end
      start(1, 1, 3, 16'h0100);
      wait_done("img_done");
      repeat (3) @(negedge clk);
      check("img_done_cnt", 32'(done_cnt - d0), 1);
      check("img_sb_empty", 32'(exp_q.size()), 0);

      // Weights load, immediate acks
      d0 = done_cnt; c0 = dec_cyc; m0 = dma_cyc; dly = 0;
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 16'h0010 + 16'(i)});
      start(1, 0, 4, 16'h0010);
      wait_done("wt_done");
      check("wt_no_decomp", 32'(dec_cyc - c0), 0);
      check("wt_dma_cycles", 32'(dma_cyc - m0), 4);
      check("wt_done_cnt", 32'(done_cnt - d0), 1);
      check("wt_sb_empty", 32'(exp_q.size()), 0);

      // Zero length
      c0 = dec_cyc; m0 = dma_cyc;
      start(1, 1, 0, 16'h0500);
      @(negedge clk);
      check("len0_early", {busy, done}, 2'b10);
      @(negedge clk);
      check("len0_done", 32'(done), 1);
      @(negedge clk);
      check("len0_busy_lo", 32'(busy), 0);
      check("len0_no_en", 32'(dec_cyc - c0 + dma_cyc - m0), 0);

      // Address wrap
      dly = 1;
      exp_q.push_back({1'b1, 16'hFFFF});
      exp_q.push_back({1'b1, 16'h0000});
      start(1, 0, 2, 16'hFFFF);
      wait_done("wrap_done");
      check("wrap_sb_empty", 32'(exp_q.size()), 0);

      // Stray and simultaneous pulses, interrupt edge while busy
      rsp_on = 0; d0 = done_cnt;
      start(1, 1, 2, 16'h0200);
      wait_for("stray_dec_wait", 0);
      @(posedge clk); #1 man_dma = 1;
      @(posedge clk); #1 man_dma = 0;
      @(negedge clk);
      check("stray_ignored", {decomp_en, dma_en}, 2'b10);
      @(posedge clk); #1 man_dec = 1; man_dma = 1;
      @(posedge clk); #1 man_dec = 0; man_dma = 0;
      @(negedge clk);
      check("both_to_dma", {decomp_en, dma_en}, 2'b01);
      check("both_addr", 32'(dma_addr), 32'h0200);
      @(posedge clk); #1 interrupt = 1; base_addr = 16'h0900; len = 16'd7;
      @(posedge clk); #1 interrupt = 0;
      exp_q.push_back({1'b1, 16'h0200});
      exp_q.push_back({1'b0, 16'h0});
      exp_q.push_back({1'b1, 16'h0201});
      dly = 0; rsp_on = 1;
      wait_done("stray_done");
      repeat (4) @(negedge clk);
      check("stray_done_cnt", 32'(done_cnt - d0), 1);
      check("stray_no_restart", 32'(busy), 0);
      check("stray_sb_empty", 32'(exp_q.size()), 0);

      // Host IO read path
      rsp_on = 0;
      @(posedge clk); #1 load = 0; interrupt = 1;
      @(negedge clk);
      check("io_pre", 32'(io_if_en), 0);
      @(negedge clk);
      check("io_on", {io_if_en, busy}, 2'b10);
      @(posedge clk); #1 interrupt = 0;
      @(posedge clk);
      @(negedge clk);
      check("io_off", 32'(io_if_en), 0);

      // Reset mid-DMA, then clean restart
      d0 = done_cnt;
      start(1, 0, 5, 16'h0300);
      wait_for("rst_dma_wait", 1);
      check("rst_dma_addr", 32'(dma_addr), 32'h0300);
      @(posedge clk); #2 rst = 1;
      #1 check("rst_async", {dma_en, busy}, 2'b00);
      @(posedge clk); #1 rst = 0;
      repeat (3) @(negedge clk);
      check("rst_no_done", 32'(done_cnt - d0), 0);
      dly = 0; rsp_on = 1;
      exp_q.push_back({1'b0, 16'h0});
      exp_q.push_back({1'b1, 16'h0400});
      start(1, 1, 1, 16'h0400);
      wait_done("restart_done");
      check("restart_sb_empty", 32'(exp_q.size()), 0);

      // Withheld decomp_done
      rsp_on = 0; d0 = done_cnt; e0 = err_cnt; c0 = dec_cyc;
      start(1, 1, 1, 16'h0600);
`ifdef IO_SEQ_TIMEOUT_EN
      got = 0;
      for (int i = 0; i < 60 && !got; i++) begin @(negedge clk); got = error; end
      check("to_error", 32'(got), 1);
      check("to_wait_cycles", 32'(dec_cyc - c0), 16);
      check("to_en_drop", {decomp_en, dma_en}, 2'b00);
      @(negedge clk);
      check("to_after", {error, busy}, 2'b00);
      check("to_no_done", 32'(done_cnt - d0), 0);
`else
      repeat (100) @(negedge clk);
      check("nto_still_dec", {decomp_en, busy}, 2'b11);
      check("nto_no_error", 32'(err_cnt - e0), 0);
      check("nto_no_done", 32'(done_cnt - d0), 0);
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
`endif
      check("final_sb_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/io_load_sequencer.md
Name: io_load_sequencer

Overview:
Clocked sequencer for the IO load path. It takes a load request on the interrupt line and runs a per-word transfer: decompressor then DMA write for CNN images, or DMA write only for weights. It generates DMA addresses, counts words, and reports completion. It sits between the host IO interface and the decompressor/DMA pair, replacing edge-triggered enable toggling with a single-clock FSM.

Parameters:
ADDR_W, 16, width of DMA word address
CNT_W, 16, width of transfer length and word counter
TIMEOUT, 1024, max cycles spent waiting for decomp_done/dma_done (used only with IO_SEQ_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
interrupt  in  1  host request line; a transfer starts on its rising edge
load  in  1  1 = load into accelerator memory, 0 = host IO read
cnn_img  in  1  1 = compressed image (decompress each word), 0 = weights (raw)
len  in  CNT_W  number of words to transfer, sampled at start
base_addr  in  ADDR_W  first DMA word address, sampled at start
decomp_en  out  1  request one decompressed word (level, held until decomp_done)
decomp_done  in  1  one-cycle pulse, word ready
dma_en  out  1  request one DMA write (level, held until dma_done)
dma_addr  out  ADDR_W  address for the current DMA write
dma_done  in  1  one-cycle pulse, write complete
io_if_en  out  1  host IO interface enable
busy  out  1  high from start until return to IDLE
done  out  1  one-cycle pulse, transfer finished
error  out  1  one-cycle pulse on timeout abort (tied 0 without macro)

Behaviour:
- Reset: state IDLE; all outputs 0; word counter, address and latched mode cleared. Reset mid-transfer drops enables immediately (async); no done pulse.
- Interrupt rising edge detected with a registered previous value; prev register resets to 0, so interrupt held high through reset release counts as an edge.
- IDLE:
  - io_if_en = registered (interrupt & ~load), updated every cycle, and forced 0 outside IDLE.
  - On an interrupt edge with load=1: latch cnn_img, len and base_addr; busy goes 1 next cycle.
    - len==0 -> FINISH.
    - cnn_img=1 -> DECOMP.
    - cnn_img=0 -> DMA.
  - On an interrupt edge with load=0: stay in IDLE.
- DECOMP: decomp_en=1. On decomp_done -> DMA next cycle; decomp_en drops the same edge.
- DMA: dma_en=1, dma_addr = base + count. On dma_done, count++.
  - count+1==len -> FINISH.
  - Otherwise go to DECOMP (image) or stay in DMA (weights). For weights, dma_en stays high with the new address next cycle.
- FINISH: done=1 for one cycle, busy=0 next cycle, -> IDLE.
- Latency, image: minimum 2 cycles per word (DECOMP 1 cycle + DMA 1 cycle) when done pulses return in the same cycle the request is raised.
- Address arithmetic is modulo 2^ADDR_W; base=0xFFFF, len=2 writes 0xFFFF then 0x0000.
- Counter compare is on the full CNT_W. len = 2^CNT_W-1 is legal.
- Pulses not matching the current state (dma_done in DECOMP, decomp_done in DMA, any done in IDLE/FINISH) are ignored. If both arrive in the same cycle, only the one matching the state acts.
- Interrupt edges while busy are ignored, not queued. load, cnn_img, len and base_addr changes while busy have no effect.

Optional Feature:
IO_SEQ_TIMEOUT_EN:
- Defined: a wait counter clears on entry to DECOMP/DMA and on each accepted done pulse, and increments while waiting. Reaching TIMEOUT aborts: enables drop, error pulses 1 cycle, done does not pulse, state returns to IDLE (busy 0 next cycle).
- Undefined: no counter; the block waits indefinitely and error is constant 0.

Decomposition:
- Package io_seq_pkg holds:
  - state enum IDLE/DECOMP/DMA/FINISH (2-bit encoding)
  - default widths
  - TIMEOUT default
- One natural sub-module: io_seq_watchdog (wait counter plus expiry compare), instantiated only under IO_SEQ_TIMEOUT_EN. Edge detect and address/count stay inline.

Test Plan:
- Image load: load=1, cnn_img=1, len=3, base=0x0100, decomp_done/dma_done returned 2 cycles after each request -> request order decomp, dma@0x0100, decomp, dma@0x0101, decomp, dma@0x0102; one done pulse; busy falls the cycle after done.
- Weights load: cnn_img=0, len=4, base=0x0010, dma_done immediate -> 4 consecutive DMA writes 0x0010..0x0013, decomp_en never high, done after 4th write.
- Boundaries: len=0 -> done 2 cycles after edge with no enables. base=0xFFFF, len=2 -> addresses 0xFFFF, 0x0000.
- Stray/simultaneous: dma_done pulsed in DECOMP, then decomp_done+dma_done together in DECOMP -> first ignored; second moves to DMA without counting a write. Second interrupt edge while busy -> ignored.
- IO path and reset: interrupt=1, load=0 -> io_if_en=1 next cycle, busy stays 0. Reset asserted mid-DMA of len=5 -> dma_en 0 immediately, no done, clean restart afterwards.
- With IO_SEQ_TIMEOUT_EN, TIMEOUT=16, decomp_done withheld -> error pulse after 16 waiting cycles, no done, IDLE after. Without macro -> still in DECOMP after 100 cycles, error stays 0.
